// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: ALU op encoding,
// R-type funct codes and FSM state constants.
package fetch_pkg;

    typedef enum logic [2:0] {
        ALU_NOP     = 3'd0,
        ALU_ADD     = 3'd1,
        ALU_SUB     = 3'd2,
        ALU_OR      = 3'd3,
        ALU_AND     = 3'd4,
        ALU_MUL     = 3'd5,
        ALU_ILLEGAL = 3'd6
    } alu_op_t;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_FETCH = 2'd1;
    localparam state_t S_DRAIN = 2'd2;
    localparam state_t S_DONE  = 2'd3;

endpackage

// File: rtl/rtype_decoder.sv
// Combinational MIPS R-type splitter: register fields, shamt and
// ALU op classification from a 32-bit instruction word.
module rtype_decoder
    import fetch_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output alu_op_t     alu_op
);

    assign rs    = instr[25:21];
    assign rt    = instr[20:16];
    assign rd    = instr[15:11];
    assign shamt = instr[10:6];

    always_comb begin
        alu_op = ALU_ILLEGAL;
        if (instr[31:26] == 6'd0) begin
            unique case (instr[5:0])
                FUNCT_ADD: alu_op = ALU_ADD;
                FUNCT_SUB: alu_op = ALU_SUB;
                FUNCT_OR:  alu_op = ALU_OR;
                FUNCT_AND: alu_op = ALU_AND;
                FUNCT_MUL: alu_op = ALU_MUL;
                default:   alu_op = ALU_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential reader of the instruction memory feeding a valid/ready decode stream.
// Optional ILLEGAL_TRAP_EN: stop the run and flag err on an illegal word.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] mem_index,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] instr,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output alu_op_t           alu_op,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t          state;
    logic [ADDR_W:0] remaining;
    logic [ADDR_W:0] count_eff;
    alu_op_t         dec_op;
    alu_op_t         op_q;
    logic            skip;

    rtype_decoder u_dec (
        .instr  (instr[31:0]),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .shamt  (shamt),
        .alu_op (dec_op)
    );

    assign mem_wr    = 1'b0;
    assign count_eff = (count > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : count;
    assign alu_op    = out_valid ? op_q : ALU_NOP;

`ifdef ILLEGAL_TRAP_EN
    assign op_q = dec_op;
    assign skip = out_valid && out_ready && (dec_op == ALU_ILLEGAL);

    always_ff @(posedge clk) begin
        if (rst)       err <= 1'b0;
        else if (skip) err <= 1'b1;
    end
`else
    assign op_q = (dec_op == ALU_ILLEGAL) ? ALU_NOP : dec_op;
    assign skip = 1'b0;
    assign err  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            remaining <= '0;
            mem_index <= '0;
            mem_rd    <= 1'b0;
            out_valid <= 1'b0;
            instr     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        if (count_eff == '0) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            remaining <= count_eff;
                            mem_index <= '0;
                            mem_rd    <= 1'b1;
                            busy      <= 1'b1;
                            state     <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (skip) begin
                        out_valid <= 1'b0;
                        mem_rd    <= 1'b0;
                        state     <= S_DRAIN;
                    end else if (!out_valid || out_ready) begin
                        instr     <= mem_data;
                        out_valid <= 1'b1;
                        remaining <= remaining - (ADDR_W+1)'(1);
                        // last word: stop reading without advancing the index
                        if (remaining == (ADDR_W+1)'(1)) begin
                            mem_rd <= 1'b0;
                            state  <= S_DRAIN;
                        end else begin
                            mem_index <= mem_index + ADDR_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (!out_valid || out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
// Build with +define+ILLEGAL_TRAP_EN to exercise the trap variant.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  count = '0;
    logic [4:0]  mem_index;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] instr;
    logic [4:0]  rs, rt, rd, shamt;
    alu_op_t     alu_op;
    logic        busy, done, err;

    logic [31:0] mem [32];
    alu_op_t     exp_op [32];
    assign mem_data = mem[mem_index];

    int errors = 0;
    int checks = 0;

    logic [31:0] b_instr [$];
    alu_op_t     b_op [$];
    logic [4:0]  b_rd [$];
    logic [4:0]  b_rs [$];
    int done_cnt, done_cyc, last_beat_cyc, first_valid_cyc;
    int unstable, wr_seen, valid_seen, busy_seen;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk(clk), .rst(rst), .start(start), .count(count),
        .mem_index(mem_index), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_data(mem_data), .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .alu_op(alu_op), .busy(busy), .done(done), .err(err)
    );

    function automatic logic [31:0] mk(input logic [5:0] f, input int s,
                                       input int t, input int d);
        logic [4:0] s5, t5, d5;
        s5 = 5'(s);
        t5 = 5'(t);
        d5 = 5'(d);
        return {6'd0, s5, t5, d5, 5'd0, f};
    endfunction

    // 3 each ADD, SUB, OR, AND, MUL; rd runs 3..9, 11..17, 19
    task automatic load_mix();
        logic [5:0] fn [5];
        alu_op_t    op [5];
        fn[0] = FUNCT_ADD; fn[1] = FUNCT_SUB; fn[2] = FUNCT_OR;
        fn[3] = FUNCT_AND; fn[4] = FUNCT_MUL;
        op[0] = ALU_ADD; op[1] = ALU_SUB; op[2] = ALU_OR;
        op[3] = ALU_AND; op[4] = ALU_MUL;
        for (int i = 0; i < 32; i++) begin
            mem[i]    = mk(fn[(i / 3) % 5], i, i + 1, 3 + i + i / 7);
            exp_op[i] = op[(i / 3) % 5];
        end
    endtask

    task automatic go(input logic [5:0] n);
        @(negedge clk);
        start = 1'b1;
        count = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: ready high; 1: ready toggles; 2: ready high plus a start pulse mid-run
    task automatic collect(input int mode, input int limit);
        logic [31:0] held_i;
        logic [4:0]  held_rd;
        alu_op_t     held_op;
        logic        stalled;
        b_instr.delete(); b_op.delete(); b_rd.delete(); b_rs.delete();
        done_cnt = 0; done_cyc = -1; last_beat_cyc = -1; first_valid_cyc = -1;
        unstable = 0; wr_seen = 0; valid_seen = 0; busy_seen = 0;
        stalled = 1'b0;
        held_i = '0; held_rd = '0; held_op = ALU_NOP;
        for (int cyc = 0; cyc < limit; cyc++) begin
            if (stalled && (instr !== held_i || rd !== held_rd || alu_op !== held_op))
                unstable++;
            out_ready = (mode == 1) ? cyc[0] : 1'b1;
            if (mode == 2) begin
                start = (cyc == 2);
                count = 6'd20;
            end
            if (mem_wr) wr_seen++;
            if (busy) busy_seen++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (out_valid) begin
                valid_seen++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (out_ready) begin
                    b_instr.push_back(instr);
                    b_op.push_back(alu_op);
                    b_rd.push_back(rd);
                    b_rs.push_back(rs);
                    last_beat_cyc = cyc;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_i = instr; held_rd = rd; held_op = alu_op;
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, mem_rd, mem_wr, busy, done, err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b want=000000",
                     {out_valid, mem_rd, mem_wr, busy, done, err});
        end
        checks++;
        if (mem_index !== 5'd0 || instr !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs got idx=%0d instr=%h want 0", mem_index, instr);
        end
        checks++;
        if (alu_op !== ALU_NOP || rd !== 5'd0) begin
            errors++;
            $display("FAIL reset_decode got op=%0d rd=%0d want 0", alu_op, rd);
        end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        int bad;
        load_mix();
        go(6'd15);
        collect(0, 200);
        checks++;
        if (b_instr.size() != 15) begin
            errors++;
            $display("FAIL stream_beats got=%0d want=15", b_instr.size());
        end
        bad = 0;
        for (int j = 0; j < b_instr.size() && j < 15; j++)
            if (b_instr[j] !== mem[j] || b_op[j] !== exp_op[j]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stream_order got=%0d bad beats want=0", bad);
        end
        checks++;
        if (b_rd.size() == 0 || b_rd[0] !== 5'd3 || b_op[0] !== ALU_ADD) begin
            errors++;
            $display("FAIL stream_first wrong first beat (want rd=3 ADD)");
        end
        checks++;
        if (b_rd.size() == 0 || b_rd[b_rd.size()-1] !== 5'd19 || b_op[b_op.size()-1] !== ALU_MUL) begin
            errors++;
            $display("FAIL stream_last wrong last beat (want rd=19 MUL)");
        end
        checks++;
        if (first_valid_cyc != 1) begin
            errors++;
            $display("FAIL stream_latency got=%0d want=1", first_valid_cyc);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != last_beat_cyc + 1) begin
            errors++;
            $display("FAIL stream_done got cnt=%0d cyc=%0d want cnt=1 cyc=%0d",
                     done_cnt, done_cyc, last_beat_cyc + 1);
        end
        checks++;
        if (last_beat_cyc != 15) begin
            errors++;
            $display("FAIL stream_rate got last beat at %0d want=15", last_beat_cyc);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        load_mix();
        go(6'd15);
        collect(1, 300);
        bad = 0;
        for (int j = 0; j < b_instr.size() && j < 15; j++)
            if (b_instr[j] !== mem[j]) bad++;
        checks++;
        if (b_instr.size() != 15 || bad != 0) begin
            errors++;
            $display("FAIL bp_beats got=%0d bad=%0d want=15 bad=0", b_instr.size(), bad);
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL bp_stable got=%0d changes want=0", unstable);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL bp_done got=%0d want=1", done_cnt);
        end
    endtask

    task automatic test_zero_count();
        go(6'd0);
        collect(0, 20);
        checks++;
        if (done_cnt != 1 || done_cyc < 0 || done_cyc > 1) begin
            errors++;
            $display("FAIL zero_done got cnt=%0d cyc=%0d want cnt=1 cyc<=1", done_cnt, done_cyc);
        end
        checks++;
        if (valid_seen != 0 || busy_seen != 0) begin
            errors++;
            $display("FAIL zero_idle got valid=%0d busy=%0d want 0", valid_seen, busy_seen);
        end
    endtask

    task automatic test_full_depth();
        int bad;
        for (int i = 0; i < 32; i++) mem[i] = mk(FUNCT_ADD, i, 0, 1);
        go(6'd32);
        collect(0, 300);
        bad = 0;
        for (int j = 0; j < b_rs.size() && j < 32; j++)
            if (b_rs[j] !== 5'(j)) bad++;
        checks++;
        if (b_rs.size() != 32 || bad != 0) begin
            errors++;
            $display("FAIL full_index got=%0d beats bad=%0d want=32 bad=0", b_rs.size(), bad);
        end
        checks++;
        if (wr_seen != 0) begin
            errors++;
            $display("FAIL full_mem_wr got=%0d want=0", wr_seen);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL full_done got=%0d want=1", done_cnt);
        end
    endtask

    task automatic test_reset_mid_run();
        int beats, dones;
        load_mix();
        go(6'd15);
        out_ready = 1'b1;
        beats = 0;
        for (int cyc = 0; cyc < 50 && beats < 5; cyc++) begin
            if (out_valid) beats++;
            if (beats < 5) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, mem_rd, busy, done, err} !== 5'b0 || mem_index !== 5'd0
            || instr !== 32'd0 || alu_op !== ALU_NOP) begin
            errors++;
            $display("FAIL midrst_outs got v=%b rd=%b busy=%b done=%b idx=%0d instr=%h want 0",
                     out_valid, mem_rd, busy, done, mem_index, instr);
        end
        rst = 1'b0;
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL midrst_nodone got=%0d want=0", dones);
        end
        go(6'd3);
        collect(0, 50);
        checks++;
        if (b_instr.size() != 3 || b_instr[0] !== mem[0]) begin
            errors++;
            $display("FAIL midrst_restart got=%0d beats want=3 from index 0", b_instr.size());
        end
    endtask

    task automatic test_start_while_busy();
        load_mix();
        go(6'd4);
        collect(2, 100);
        checks++;
        if (b_instr.size() != 4 || done_cnt != 1) begin
            errors++;
            $display("FAIL busy_start got beats=%0d done=%0d want 4 and 1", b_instr.size(), done_cnt);
        end
    endtask

    task automatic test_illegal();
        load_mix();
        mem[2] = 32'hFC000000;
        go(6'd15);
        collect(0, 200);
`ifdef ILLEGAL_TRAP_EN
        checks++;
        if (b_instr.size() != 3 || b_op.size() < 3 || b_op[2] !== ALU_ILLEGAL) begin
            errors++;
            $display("FAIL trap_beats got=%0d want=3 ending ILLEGAL", b_instr.size());
        end
        checks++;
        if (err !== 1'b1 || done_cnt != 1) begin
            errors++;
            $display("FAIL trap_err got err=%b done=%0d want 1 and 1", err, done_cnt);
        end
`else
        checks++;
        if (b_instr.size() != 15 || b_op.size() < 3 || b_op[2] !== ALU_NOP) begin
            errors++;
            $display("FAIL pass_beats got=%0d want=15 with beat2 NOP", b_instr.size());
        end
        checks++;
        if (err !== 1'b0 || done_cnt != 1) begin
            errors++;
            $display("FAIL pass_err got err=%b done=%0d want 0 and 1", err, done_cnt);
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i] = '0;
            exp_op[i] = ALU_NOP;
        end
        test_reset();
        test_stream();
        test_backpressure();
        test_zero_count();
        test_full_depth();
        test_reset_mid_run();
        test_start_while_busy();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
